bcd2binary: RTL and testbench

Sequential BCD-to-binary converter using reverse double-dabble: shift right one bit per clock, then apply a −3 correction to each BCD digit. It turns 6-digit packed BCD (for example from keypad or parameter entry) into a 20-bit binary value for datapath use. It is the inverse companion of the team's binary-to-BCD display converter. A valid/ready handshake on the input and a single-cycle result strobe on the output let it sit between a BCD source and binary logic.

---
 rtl/bcd2binary.sv | 118 +++++++++++
 tb/tb_bcd2binary.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd2binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One right shift plus per-digit -3 correction per clock; BIN_WIDTH iterations per result.
module bcd2binary #(
  parameter int unsigned BCD_DIGITS = 6,
  parameter int unsigned BIN_WIDTH  = 20
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    bcd_valid,
  input  logic [4*BCD_DIGITS-1:0] bcd_data,
  output logic                    bcd_ready,
  output logic [BIN_WIDTH-1:0]    bin_data,
  output logic                    bin_valid,
  output logic                    bcd_err
);

  localparam int unsigned BcdW = 4 * BCD_DIGITS;
  localparam int unsigned RegW = BcdW + BIN_WIDTH;
  localparam int unsigned CntW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CntW-1:0] LastIter = CntW'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [RegW-1:0]      sreg_q, sreg_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [BIN_WIDTH-1:0] bin_data_q, bin_data_d;
  logic                 bin_valid_q, bin_valid_d;
  logic                 bcd_err_q, bcd_err_d;

  logic [RegW-1:0]      shifted;
  logic [RegW-1:0]      corrected;
  logic                 in_err;

  // Any nibble above 9 marks the whole input as invalid BCD.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      in_err = in_err | (bcd_data[4*i +: 4] > 4'd9);
    end
  end

  // One iteration: shift right, then pull each BCD digit that reached 8+ back by 3.
  always_comb begin
    shifted   = sreg_q >> 1;
    corrected = shifted;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (shifted[BIN_WIDTH + 4*i +: 4] >= 4'd8) begin
        corrected[BIN_WIDTH + 4*i +: 4] = shifted[BIN_WIDTH + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    bin_data_d  = bin_data_q;
    bin_valid_d = 1'b0;
    bcd_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bcd_valid) begin
          sreg_d  = {bcd_data, {BIN_WIDTH{1'b0}}};
          cnt_d   = '0;
          err_d   = in_err;
          state_d = StConv;
        end
      end
      StConv: begin
        sreg_d = corrected;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastIter) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bin_data_d  = err_q ? '0 : sreg_q[BIN_WIDTH-1:0];
        bcd_err_d   = err_q;
        bin_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      bin_data_q  <= '0;
      bin_valid_q <= 1'b0;
      bcd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      bin_data_q  <= bin_data_d;
      bin_valid_q <= bin_valid_d;
      bcd_err_q   <= bcd_err_d;
    end
  end

  assign bcd_ready = (state_q == StIdle);
  assign bin_data  = bin_data_q;
  assign bin_valid = bin_valid_q;
  assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_bcd2binary.sv
// Self-checking bench for bcd2binary: directed boundary cases plus random BCD,
// checked against a decimal-arithmetic reference model.
module tb_bcd2binary;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        bcd_valid;
  logic [23:0] bcd_data;
  logic        bcd_ready;
  logic [19:0] bin_data;
  logic        bin_valid;
  logic        bcd_err;

  int tests_run;
  int tests_failed;

  bcd2binary #(
    .BCD_DIGITS(6),
    .BIN_WIDTH (20)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bcd_valid(bcd_valid),
    .bcd_data (bcd_data),
    .bcd_ready(bcd_ready),
    .bin_data (bin_data),
    .bin_valid(bin_valid),
    .bcd_err  (bcd_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decimal value of the digits; any digit over 9 yields error and a zero result.
  task automatic ref_model(input logic [23:0] bcd, output logic [19:0] val, output logic err);
    int unsigned acc;
    int unsigned weight;
    int unsigned digit;
    acc    = 0;
    weight = 1;
    err    = 1'b0;
    for (int k = 0; k < 6; k++) begin
      digit  = (bcd >> (4 * k)) & 32'hF;
      if (digit > 9) err = 1'b1;
      acc    = acc + digit * weight;
      weight = weight * 10;
    end
    val = err ? 20'h0 : acc[19:0];
  endtask

  // Wait for bin_valid (bounded); counts edges and any cycle where ready was wrongly high.
  task automatic wait_result(output int edges, output int rdy_hi);
    edges  = 0;
    rdy_hi = 0;
    do begin
      @(posedge sys_clk);
      #1;
      edges++;
      if (!bin_valid && bcd_ready) rdy_hi++;
    end while (!bin_valid && edges < 40);
  endtask

  task automatic check_result(input string tag, input logic [23:0] bcd);
    logic [19:0] ev;
    logic        ee;
    ref_model(bcd, ev, ee);
    check_val({tag, ":valid"}, 32'(bin_valid), 32'd1);
    check_val({tag, ":data"}, 32'(bin_data), 32'(ev));
    check_val({tag, ":err"}, 32'(bcd_err), 32'(ee));
    check_val({tag, ":ready"}, 32'(bcd_ready), 32'd1);
  endtask

  // Called #1 after an edge with the converter idle.
  task automatic run_one(input string tag, input logic [23:0] bcd);
    int n;
    int rh;
    check_val({tag, ":idle"}, 32'(bcd_ready), 32'd1);
    bcd_valid = 1'b1;
    bcd_data  = bcd;
    @(posedge sys_clk);
    #1;
    bcd_valid = 1'b0;
    bcd_data  = $urandom;
    wait_result(n, rh);
    check_val({tag, ":lat"}, 32'(n), 32'd21);
    check_val({tag, ":busy"}, 32'(rh), 32'd0);
    check_result(tag, bcd);
    @(posedge sys_clk);
    #1;
    check_val({tag, ":strobe"}, 32'(bin_valid), 32'd0);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge sys_clk);
      #1;
      if (bin_valid || bcd_err) pulses++;
    end
  endtask

  initial begin
    int          n;
    int          rh;
    int          p;
    logic [23:0] r;

    tests_run    = 0;
    tests_failed = 0;
    sys_rst_n    = 1'b0;
    bcd_valid    = 1'b0;
    bcd_data     = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_val("rst:ready", 32'(bcd_ready), 32'd1);
    check_val("rst:data", 32'(bin_data), 32'd0);
    check_val("rst:valid", 32'(bin_valid), 32'd0);
    check_val("rst:err", 32'(bcd_err), 32'd0);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    run_one("d123456", 24'h123456);
    run_one("d000000", 24'h000000);
    run_one("d999999", 24'h999999);
    run_one("d065535", 24'h065535);
    run_one("d000001", 24'h000001);
    run_one("e00000A", 24'h00000A);
    run_one("eF00000", 24'hF00000);
    run_one("d000042", 24'h000042);

    // Back-to-back with valid held high.
    bcd_valid = 1'b1;
    bcd_data  = 24'h000100;
    @(posedge sys_clk);
    #1;
    bcd_data = 24'h000250;
    wait_result(n, rh);
    check_val("b2b1:lat", 32'(n), 32'd21);
    check_result("b2b1", 24'h000100);
    @(posedge sys_clk);
    #1;
    bcd_valid = 1'b0;
    check_val("b2b2:accepted", 32'(bcd_ready), 32'd0);
    wait_result(n, rh);
    check_val("b2b2:lat", 32'(n), 32'd21);
    check_result("b2b2", 24'h000250);

    // Busy-ignore: new request while converting only starts once ready returns.
    bcd_valid = 1'b1;
    bcd_data  = 24'h000123;
    @(posedge sys_clk);
    #1;
    repeat (5) @(posedge sys_clk);
    #1;
    bcd_data = 24'h777777;
    wait_result(n, rh);
    check_val("busy1:lat", 32'(n), 32'd16);
    check_result("busy1", 24'h000123);
    @(posedge sys_clk);
    #1;
    bcd_valid = 1'b0;
    wait_result(n, rh);
    check_val("busy2:lat", 32'(n), 32'd21);
    check_result("busy2", 24'h777777);
    count_pulses(30, p);
    check_val("busy:extra", 32'(p), 32'd0);

    // Reset mid-conversion.
    bcd_valid = 1'b1;
    bcd_data  = 24'h654321;
    @(posedge sys_clk);
    #1;
    bcd_valid = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    check_val("mrst:ready", 32'(bcd_ready), 32'd1);
    check_val("mrst:data", 32'(bin_data), 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    count_pulses(30, p);
    check_val("mrst:nopulse", 32'(p), 32'd0);
    check_val("mrst:data2", 32'(bin_data), 32'd0);
    run_one("mrst:next", 24'h000042);

    // Random: mostly valid BCD, some raw words that may contain bad digits.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = 24'($urandom);
      end else begin
        for (int k = 0; k < 6; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      repeat ($urandom_range(0, 3)) @(posedge sys_clk);
      #1;
      run_one($sformatf("rnd%0d_%06h", t, r), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
